// File: rtl/adder_cmd_sequencer_if.sv
// Bus bundle between the adder command sequencer and its surroundings:
// the UART RX/TX byte streams and the adder operand/handshake lines.
// The master modport is the sequencer's view. The slave modport is the
// environment's view: the UART blocks and the adder datapath.
interface adder_cmd_sequencer_if;
  // UART RX byte stream
  logic       rx_valid;
  logic [7:0] rx_data;
  // UART TX byte stream
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  // Adder datapath
  logic [7:0] r1;
  logic [7:0] r2;
  logic       subtract;
  logic       adder_start;
  logic [7:0] adder_data;
  logic       adder_rdy;
  // Status
  logic       busy;
  logic       rx_drop;

  modport master (
    input  rx_valid, rx_data, tx_ready, adder_data, adder_rdy,
    output tx_valid, tx_data, r1, r2, subtract, adder_start, busy, rx_drop
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, adder_data, adder_rdy,
    input  tx_valid, tx_data, r1, r2, subtract, adder_start, busy, rx_drop
  );
endinterface

// File: rtl/adder_cmd_sequencer.sv
// Adder command sequencer: the initiator side of the Lab2 adder handshake.
// It parses "<digit><op><digit>" from the console RX stream, ignoring spaces.
// It launches the combinational adder with a one-cycle start pulse and waits
// for the adder's ready pulse, with a timeout.
// It then sends the returned character, followed by CR LF, to the TX stream.
// A parse error sends ERR_CHAR in place of the result.
// An adder timeout sends TMO_CHAR in place of the result.
// Every output is registered.
module adder_cmd_sequencer #(
  parameter int unsigned RDY_TIMEOUT = 16,
  parameter logic [7:0]  ERR_CHAR    = 8'h23,
  parameter logic [7:0]  TMO_CHAR    = 8'h21
) (
  input  logic                 clk,
  input  logic                 rst,
  adder_cmd_sequencer_if.master bus
);

  localparam int unsigned TW = (RDY_TIMEOUT > 2) ? $clog2(RDY_TIMEOUT) : 1;

  // The timeout decision is taken while timer still holds RDY_TIMEOUT-2.
  // At that point the incremented count reaches RDY_TIMEOUT-1.
  // As a result, the timeout character is presented exactly RDY_TIMEOUT
  // cycles after the start pulse.
  localparam logic [TW-1:0] TMO_LAST = TW'(RDY_TIMEOUT - 2);

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  typedef enum logic [3:0] {
    IDLE,
    GET_OP,
    GET_OP2,
    ISSUE,
    WAIT_RDY,
    ERR,
    SEND_RES,
    SEND_CR,
    SEND_LF
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;

  logic is_digit;
  logic is_space;
  logic rx_char;
  logic parse_state;
  logic tx_accept;

  // Character classification and handshake qualifiers
  always_comb begin
    is_digit    = (bus.rx_data[7:4] == 4'h3);
    is_space    = (bus.rx_data == CH_SPACE);
    rx_char     = bus.rx_valid && !is_space;
    parse_state = (state == IDLE) || (state == GET_OP) || (state == GET_OP2);
    tx_accept   = bus.tx_valid && bus.tx_ready;
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      timer           <= '0;
      bus.r1          <= '0;
      bus.r2          <= '0;
      bus.subtract    <= 1'b0;
      bus.adder_start <= 1'b0;
      bus.tx_valid    <= 1'b0;
      bus.tx_data     <= '0;
      bus.busy        <= 1'b0;
      bus.rx_drop     <= 1'b0;
    end else begin
      bus.adder_start <= 1'b0;
      bus.rx_drop     <= bus.rx_valid && !parse_state;

      unique case (state)
        IDLE: begin
          if (rx_char) begin
            bus.busy <= 1'b1;
            if (is_digit) begin
              bus.r1 <= bus.rx_data;
              state  <= GET_OP;
            end else begin
              state  <= ERR;
            end
          end
        end

        GET_OP: begin
          if (rx_char) begin
            if (bus.rx_data == CH_PLUS) begin
              bus.subtract <= 1'b0;
              state        <= GET_OP2;
            end else if (bus.rx_data == CH_MINUS) begin
              bus.subtract <= 1'b1;
              state        <= GET_OP2;
            end else begin
              state        <= ERR;
            end
          end
        end

        GET_OP2: begin
          if (rx_char) begin
            if (is_digit) begin
              bus.r2          <= bus.rx_data;
              bus.adder_start <= 1'b1;
              state           <= ISSUE;
            end else begin
              state           <= ERR;
            end
          end
        end

        ISSUE: begin
          timer <= '0;
          state <= WAIT_RDY;
        end

        WAIT_RDY: begin
          if (bus.adder_rdy) begin
            bus.tx_data  <= bus.adder_data;
            bus.tx_valid <= 1'b1;
            state        <= SEND_RES;
          end else begin
            timer <= timer + 1'b1;
            if (timer == TMO_LAST) begin
              bus.tx_data  <= TMO_CHAR;
              bus.tx_valid <= 1'b1;
              state        <= SEND_RES;
            end
          end
        end

        ERR: begin
          bus.tx_data  <= ERR_CHAR;
          bus.tx_valid <= 1'b1;
          state        <= SEND_RES;
        end

        SEND_RES: begin
          if (tx_accept) begin
            bus.tx_data <= CH_CR;
            state       <= SEND_CR;
          end
        end

        SEND_CR: begin
          if (tx_accept) begin
            bus.tx_data <= CH_LF;
            state       <= SEND_LF;
          end
        end

        SEND_LF: begin
          if (tx_accept) begin
            bus.tx_valid <= 1'b0;
            bus.busy     <= 1'b0;
            state        <= IDLE;
          end
        end

        default: begin
          bus.tx_valid <= 1'b0;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
